// File: rtl/axis_wr_desc_ctrl_if.sv
// Bundles the descriptor, upstream stream, bridge stream, base-address and status
// signals of the write descriptor controller; slave is the controller's view.
interface axis_wr_desc_ctrl_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34,
  parameter int LEN_WIDTH  = 20,
  parameter int TAG_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] s_desc_addr;
  logic [LEN_WIDTH-1:0]  s_desc_len;
  logic [TAG_WIDTH-1:0]  s_desc_tag;
  logic                  s_desc_valid;
  logic                  s_desc_ready;

  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_axis_tkeep;
  logic                  s_axis_tlast;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  logic [ADDR_WIDTH-1:0] m_base_addr;
  logic                  m_base_addr_valid;

  logic [TAG_WIDTH-1:0]  m_status_tag;
  logic [LEN_WIDTH-1:0]  m_status_len;
  logic                  m_status_error;
  logic                  m_status_valid;

  modport slave (
    input  s_desc_addr, s_desc_len, s_desc_tag, s_desc_valid,
    output s_desc_ready,
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready,
    output m_base_addr, m_base_addr_valid,
    output m_status_tag, m_status_len, m_status_error, m_status_valid
  );

  modport master (
    output s_desc_addr, s_desc_len, s_desc_tag, s_desc_valid,
    input  s_desc_ready,
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready,
    input  m_base_addr, m_base_addr_valid,
    input  m_status_tag, m_status_len, m_status_error, m_status_valid
  );
endinterface

// File: rtl/axis_wr_desc_ctrl.sv
// Write descriptor controller: loads the bridge base address, forwards one packet and
// reports its completion. AXIS_WR_DESC_DRAIN_EN enables length truncation and tail draining.
module axis_wr_desc_ctrl #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34,
  parameter int LEN_WIDTH  = 20,
  parameter int TAG_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  axis_wr_desc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, XFER, DRAIN, STATUS} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  error_q, error_d;

  logic [LEN_WIDTH-1:0]  beat_bytes;
  logic [LEN_WIDTH-1:0]  fwd_bytes;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] pass_data;
  logic                  xfer_beat;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + LEN_WIDTH'(bus.s_axis_tkeep[i]);
    end
  end

`ifdef AXIS_WR_DESC_DRAIN_EN
  logic [LEN_WIDTH-1:0]  remaining;
  logic [KEEP_WIDTH-1:0] keep_mask;
  logic                  reach;

  // The beat that reaches the descriptor length is cut down to the bytes still owed.
  always_comb begin
    remaining = len_q - count_q;
    reach     = (remaining <= beat_bytes);
    keep_mask = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_mask[i] = (LEN_WIDTH'(i) < remaining);
    end
    fwd_bytes = reach ? remaining : beat_bytes;
    out_keep  = reach ? (bus.s_axis_tkeep & keep_mask) : bus.s_axis_tkeep;
    out_last  = reach | bus.s_axis_tlast;
  end
`else
  always_comb begin
    fwd_bytes = beat_bytes;
    out_keep  = bus.s_axis_tkeep;
    out_last  = bus.s_axis_tlast;
  end
`endif

  assign pass_data = bus.s_axis_tdata;
  assign xfer_beat = (state_q == XFER) && bus.s_axis_tvalid && bus.m_axis_tready;

  assign bus.s_desc_ready      = (state_q == IDLE);
  assign bus.m_base_addr       = addr_q;
  assign bus.m_base_addr_valid = (state_q == ADDR);
  assign bus.m_axis_tdata      = pass_data;
  assign bus.m_axis_tkeep      = out_keep;
  assign bus.m_axis_tlast      = out_last;
  assign bus.m_axis_tvalid     = (state_q == XFER) && bus.s_axis_tvalid;
  assign bus.s_axis_tready     = ((state_q == XFER) && bus.m_axis_tready) || (state_q == DRAIN);
  assign bus.m_status_tag      = tag_q;
  assign bus.m_status_len      = count_q;
  assign bus.m_status_error    = error_q;
  assign bus.m_status_valid    = (state_q == STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.s_desc_valid) begin
      addr_q <= bus.s_desc_addr;
      len_q  <= bus.s_desc_len;
      tag_q  <= bus.s_desc_tag;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (bus.s_desc_valid) begin
          count_d = '0;
          error_d = (bus.s_desc_len == '0);
          state_d = (bus.s_desc_len == '0) ? STATUS : ADDR;
        end
      end
      ADDR: state_d = XFER;
      XFER: begin
        if (xfer_beat) begin
          count_d = count_q + fwd_bytes;
`ifdef AXIS_WR_DESC_DRAIN_EN
          if (reach) begin
            state_d = bus.s_axis_tlast ? STATUS : DRAIN;
            error_d = !bus.s_axis_tlast;
          end else if (bus.s_axis_tlast) begin
            state_d = STATUS;
            error_d = 1'b1;
          end
`else
          // Without draining the packet boundary alone ends the transfer.
          if (bus.s_axis_tlast) begin
            state_d = STATUS;
            error_d = ((count_q + fwd_bytes) != len_q);
          end
`endif
        end
      end
`ifdef AXIS_WR_DESC_DRAIN_EN
      DRAIN: begin
        if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
          state_d = STATUS;
        end
      end
`endif
      STATUS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_wr_desc_ctrl.sv
// Self-checking bench for axis_wr_desc_ctrl: spec vector table, ready toggling,
// reset mid-transfer and randomized packets against a byte-level reference model.
module tb_axis_wr_desc_ctrl;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int AW = 34;
  localparam int LW = 20;
  localparam int TW = 8;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_wr_desc_ctrl_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW),
                         .LEN_WIDTH(LW), .TAG_WIDTH(TW)) bus ();

  axis_wr_desc_ctrl #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW),
                      .LEN_WIDTH(LW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int len;
    int tag;
    int n;
    int b0;
    int b1;
    int b2;
    int exp_beats;
    int exp_last_bytes;
    int exp_stat_len;
    bit exp_err;
  } tv_t;

  tv_t tv[6];

  // Packet under test and the expected result for it.
  int              in_n;
  int              in_bytes[MAXB];
  bit              in_last[MAXB];
  logic [DW-1:0]   in_data[MAXB];
  int              exp_n;
  int              exp_bytes[MAXB];
  bit              exp_last[MAXB];
  int              exp_src[MAXB];
  int              exp_stat_len;
  bit              exp_err;
  int              exp_addr;

  // Observed outputs, appended by the monitor only.
  logic [AW-1:0]   mon_addr_q[$];
  int              mon_addr_cyc_q[$];
  logic [KW-1:0]   mon_keep_q[$];
  bit              mon_last_q[$];
  logic [DW-1:0]   mon_data_q[$];
  logic [TW-1:0]   mon_tag_q[$];
  logic [LW-1:0]   mon_len_q[$];
  bit              mon_err_q[$];
  int              mon_stat_cyc_q[$];

  int ready_mode = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_base_addr_valid) begin
        mon_addr_q.push_back(bus.m_base_addr);
        mon_addr_cyc_q.push_back(cyc);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        mon_keep_q.push_back(bus.m_axis_tkeep);
        mon_last_q.push_back(bus.m_axis_tlast);
        mon_data_q.push_back(bus.m_axis_tdata);
      end
      if (bus.m_status_valid) begin
        mon_tag_q.push_back(bus.m_status_tag);
        mon_len_q.push_back(bus.m_status_len);
        mon_err_q.push_back(bus.m_status_error);
        mon_stat_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.m_axis_tready = $urandom_range(0, 1) == 1;
        2:       bus.m_axis_tready = 1'b0;
        default: bus.m_axis_tready = 1'b1;
      endcase
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [KW-1:0] keep_mask(input int b);
    logic [KW-1:0] m;
    m = '0;
    for (int i = 0; i < KW; i++) m[i] = (i < b);
    return m;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Byte-accounting reference: what the bridge should see for descriptor length len.
  function automatic void ref_model(input int len);
    int acc;
    int take;
    exp_n = 0;
    acc = 0;
    exp_err = (len == 0);
    exp_addr = (len != 0) ? 1 : 0;
    if (len != 0) begin
`ifdef AXIS_WR_DESC_DRAIN_EN
      for (int i = 0; i < in_n; i++) begin
        take = (in_bytes[i] < len - acc) ? in_bytes[i] : len - acc;
        acc += take;
        exp_bytes[exp_n] = take;
        exp_last[exp_n]  = in_last[i] || (acc == len);
        exp_src[exp_n]   = i;
        exp_n++;
        if (acc == len) begin
          exp_err = !in_last[i];
          break;
        end
        if (in_last[i]) begin
          exp_err = 1'b1;
          break;
        end
      end
`else
      for (int i = 0; i < in_n; i++) begin
        acc += in_bytes[i];
        exp_bytes[exp_n] = in_bytes[i];
        exp_last[exp_n]  = in_last[i];
        exp_src[exp_n]   = i;
        exp_n++;
        if (in_last[i]) break;
      end
      exp_err = (acc != len);
`endif
    end
    exp_stat_len = acc;
  endfunction

  // Presents one descriptor and its beats, then waits for the completion report.
  task automatic apply_stimulus(input int len, input logic [TW-1:0] tag, input logic [AW-1:0] addr,
                                output int acc_cyc);
    bit fire;
    bit got;
    bus.s_desc_addr  = addr;
    bus.s_desc_len   = LW'(len);
    bus.s_desc_tag   = tag;
    bus.s_desc_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      fire = bus.s_desc_ready;
      @(posedge clk);
      #1;
      got = fire;
    end
    bus.s_desc_valid = 1'b0;
    acc_cyc = cyc;
    if (!got) check_output("desc_accept_timeout", 0, 1);
    for (int i = 0; i < in_n; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = in_data[i];
      bus.s_axis_tkeep  = keep_mask(in_bytes[i]);
      bus.s_axis_tlast  = in_last[i];
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        fire = bus.s_axis_tready;
        @(posedge clk);
        #1;
        got = fire;
      end
      if (!got) begin
        check_output("beat_accept_timeout", i, -1);
        break;
      end
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_status(input int base);
    for (int t = 0; t < 40 && mon_tag_q.size() <= base; t++) begin
      @(posedge clk);
      #1;
    end
    if (mon_tag_q.size() <= base) check_output("status_timeout", 0, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_packet(input int len, input logic [TW-1:0] tag, input logic [AW-1:0] addr,
                            input string name);
    int ab, bb, sb, acc_cyc, nb;
    ab = mon_addr_q.size();
    bb = mon_keep_q.size();
    sb = mon_tag_q.size();
    apply_stimulus(len, tag, addr, acc_cyc);
    wait_status(sb);
    check_output({name, ".addr_pulses"}, mon_addr_q.size() - ab, exp_addr);
    if (exp_addr == 1 && mon_addr_q.size() > ab) begin
      check_output({name, ".base_addr"}, longint'(mon_addr_q[ab]), longint'(addr));
      check_output({name, ".addr_latency"}, mon_addr_cyc_q[ab], acc_cyc);
    end
    nb = mon_keep_q.size() - bb;
    check_output({name, ".beats_out"}, nb, exp_n);
    for (int i = 0; i < exp_n && i < nb; i++) begin
      check_output({name, ".tkeep"}, longint'($countones(mon_keep_q[bb+i])), exp_bytes[i]);
      check_output({name, ".tkeep_contig"}, longint'(mon_keep_q[bb+i] == keep_mask(exp_bytes[i])), 1);
      check_output({name, ".tlast"}, mon_last_q[bb+i], exp_last[i]);
      check_output({name, ".tdata"}, longint'(mon_data_q[bb+i] == in_data[exp_src[i]]), 1);
    end
    check_output({name, ".status_pulses"}, mon_tag_q.size() - sb, 1);
    if (mon_tag_q.size() > sb) begin
      check_output({name, ".status_tag"}, longint'(mon_tag_q[sb]), longint'(tag));
      check_output({name, ".status_len"}, longint'(mon_len_q[sb]), exp_stat_len);
      check_output({name, ".status_err"}, mon_err_q[sb], exp_err);
      if (len == 0) check_output({name, ".zero_len_latency"}, mon_stat_cyc_q[sb], acc_cyc);
    end
  endtask

  task automatic load_table_entry(input tv_t e);
    int bs[3];
    bs[0] = e.b0;
    bs[1] = e.b1;
    bs[2] = e.b2;
    in_n = e.n;
    for (int i = 0; i < in_n; i++) begin
      in_bytes[i] = bs[i];
      in_last[i]  = (i == in_n - 1);
      in_data[i]  = rand_data();
    end
    exp_n = e.exp_beats;
    for (int i = 0; i < exp_n; i++) begin
      exp_bytes[i] = (i == exp_n - 1) ? e.exp_last_bytes : in_bytes[i];
      exp_last[i]  = (i == exp_n - 1);
      exp_src[i]   = i;
    end
    exp_stat_len = e.exp_stat_len;
    exp_err      = e.exp_err;
    exp_addr     = (e.len != 0) ? 1 : 0;
  endtask

  initial begin
    int base_beats, base_stat, sum, len, acc_cyc;

    tv[0] = '{len:128, tag:5, n:2, b0:64, b1:64, b2:0, exp_beats:2, exp_last_bytes:64, exp_stat_len:128, exp_err:0};
    tv[3] = '{len:200, tag:3, n:1, b0:64, b1:0,  b2:0, exp_beats:1, exp_last_bytes:64, exp_stat_len:64,  exp_err:1};
    tv[4] = '{len:0,   tag:9, n:0, b0:0,  b1:0,  b2:0, exp_beats:0, exp_last_bytes:0,  exp_stat_len:0,   exp_err:1};
`ifdef AXIS_WR_DESC_DRAIN_EN
    tv[1] = '{len:100, tag:6, n:2, b0:64, b1:64, b2:0,  exp_beats:2, exp_last_bytes:36, exp_stat_len:100, exp_err:0};
    tv[2] = '{len:64,  tag:7, n:3, b0:64, b1:64, b2:64, exp_beats:1, exp_last_bytes:64, exp_stat_len:64,  exp_err:1};
    tv[5] = '{len:10,  tag:1, n:1, b0:16, b1:0,  b2:0,  exp_beats:1, exp_last_bytes:10, exp_stat_len:10,  exp_err:0};
`else
    tv[1] = '{len:100, tag:6, n:2, b0:64, b1:64, b2:0,  exp_beats:2, exp_last_bytes:64, exp_stat_len:128, exp_err:1};
    tv[2] = '{len:64,  tag:7, n:3, b0:64, b1:64, b2:64, exp_beats:3, exp_last_bytes:64, exp_stat_len:192, exp_err:1};
    tv[5] = '{len:10,  tag:1, n:1, b0:16, b1:0,  b2:0,  exp_beats:1, exp_last_bytes:16, exp_stat_len:16,  exp_err:1};
`endif

    rst = 1'b1;
    bus.s_desc_valid  = 1'b0;
    bus.s_desc_addr   = '0;
    bus.s_desc_len    = '0;
    bus.s_desc_tag    = '0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '1;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset.s_desc_ready", bus.s_desc_ready, 1);
    check_output("reset.base_addr_valid", bus.m_base_addr_valid, 0);
    check_output("reset.status_valid", bus.m_status_valid, 0);
    check_output("reset.m_axis_tvalid", bus.m_axis_tvalid, 0);
    check_output("reset.s_axis_tready", bus.s_axis_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) begin
      load_table_entry(tv[k]);
      run_packet(tv[k].len, TW'(tv[k].tag), AW'(34'h1_0000_0000 + k * 64), $sformatf("table%0d", k));
    end

    // Downstream backpressure must not lose or repeat beats.
    ready_mode = 1;
    for (int r = 0; r < 3; r++) begin
      load_table_entry(tv[0]);
      run_packet(128, TW'(5), AW'(34'h2_0000_0040), "toggle_ready");
    end
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Reset in the middle of a transfer.
    in_n = 1;
    in_bytes[0] = 64;
    in_last[0]  = 1'b0;
    in_data[0]  = rand_data();
    base_beats  = mon_keep_q.size();
    base_stat   = mon_tag_q.size();
    apply_stimulus(256, TW'(8'hA5), AW'(34'h0_0000_1000), acc_cyc);
    check_output("rst_mid.first_beat", mon_keep_q.size() - base_beats, 1);
    ready_mode = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = rand_data();
    bus.s_axis_tkeep  = '1;
    bus.s_axis_tlast  = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_mid.idle_next", bus.s_desc_ready, 1);
    check_output("rst_mid.s_axis_tready", bus.s_axis_tready, 0);
    check_output("rst_mid.m_axis_tvalid", bus.m_axis_tvalid, 0);
    ready_mode = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check_output("rst_mid.no_more_beats", mon_keep_q.size() - base_beats, 1);
    check_output("rst_mid.no_status", mon_tag_q.size() - base_stat, 0);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 40; k++) begin
      ready_mode = $urandom_range(0, 1);
      in_n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      sum = 0;
      for (int i = 0; i < in_n; i++) begin
        in_bytes[i] = $urandom_range(1, KW);
        in_last[i]  = (i == in_n - 1);
        in_data[i]  = rand_data();
        sum += in_bytes[i];
      end
      if (in_n == 0) len = 0;
      else if ($urandom_range(0, 2) == 0) len = sum;
      else len = $urandom_range(1, 300);
      ref_model(len);
      run_packet(len, TW'($urandom), AW'({$urandom, $urandom}), $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=%0d expected=%0d", cyc, 0);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/axis_wr_desc_ctrl.md
AXIS_WR_DESC_CTRL -- requirements
Module: axis_wr_desc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, stream data width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 34, byte address width.
REQ-004 SHALL have parameters LEN_WIDTH (default 20, byte length width) and TAG_WIDTH (default 8, descriptor tag width).
REQ-005 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports s_desc_addr (in, ADDR_WIDTH), s_desc_len (in, LEN_WIDTH, bytes) and s_desc_tag (in, TAG_WIDTH), plus s_desc_valid (in, 1) and s_desc_ready (out, 1), forming the descriptor handshake.
REQ-008 SHALL have ports s_axis_tdata/tkeep/tlast/tvalid (in) and s_axis_tready (out), forming the upstream packet stream.
REQ-009 SHALL have ports m_axis_tdata/tkeep/tlast/tvalid (out) and m_axis_tready (in), forming the stream toward the AXIS-to-MM write bridge.
REQ-010 SHALL have ports m_base_addr (out, ADDR_WIDTH) and m_base_addr_valid (out, 1), carrying the bridge base-address load.
REQ-011 SHALL have ports m_status_tag (out, TAG_WIDTH), m_status_len (out, LEN_WIDTH), m_status_error (out, 1) and m_status_valid (out, 1), carrying the completion report.

Function
REQ-012 SHALL implement the states IDLE, ADDR, XFER, DRAIN and STATUS.
REQ-013 IDLE: s_desc_ready=1; on s_desc_valid, SHALL latch addr/len/tag, clear byte counter and error, then go to ADDR (len!=0) or STATUS with error=1 (len=0).
REQ-014 ADDR: SHALL drive m_base_addr=latched addr and m_base_addr_valid=1 for exactly one cycle, then go to XFER.
REQ-015 XFER: SHALL combinationally set m_axis_tvalid=s_axis_tvalid and s_axis_tready=m_axis_tready, and pass tdata unchanged; a beat transfers when tvalid&&tready.
REQ-016 SHALL take beat byte count = popcount(tkeep), counting all KEEP_WIDTH bits; tkeep is low-contiguous.
REQ-017 SHALL set remaining = len - counter; if remaining <= beat bytes, m_axis_tkeep = low `remaining` bits of tkeep and m_axis_tlast=1; otherwise tkeep/tlast pass through.
REQ-018 SHALL add the forwarded (masked) byte count to the counter on each transferred beat.
REQ-019 On a transferred beat with s_axis_tlast=1 before the length is reached, SHALL go to STATUS with error=1 (short packet).
REQ-020 On a beat exactly meeting the length with s_axis_tlast=1, SHALL go to STATUS with error=0.
REQ-021 On a beat reaching the length with s_axis_tlast=0, SHALL go to DRAIN with error=1.
REQ-022 DRAIN: s_axis_tready=1 and m_axis_tvalid=0; SHALL discard beats until one with tlast, then go to STATUS.
REQ-023 Outside XFER/DRAIN, s_axis_tready=0 and m_axis_tvalid=0.
REQ-024 STATUS: SHALL pulse m_status_valid for one cycle with the latched tag, m_status_len=counter and the error flag, then go to IDLE.
REQ-025 SHALL keep s_desc_ready=0 in every state except IDLE; one descriptor is in flight at a time.
REQ-026 Descriptor-to-first-data latency SHALL be 2 cycles (IDLE->ADDR->XFER).

Reset
REQ-027 On rst, SHALL set state=IDLE and drive m_base_addr_valid, m_status_valid, m_axis_tvalid and s_axis_tready to 0, and counter/error to 0.
REQ-028 Reset mid-packet SHALL abandon the transfer with no status pulse and no further beats forwarded.

Configuration
REQ-029 Macro AXIS_WR_DESC_DRAIN_EN defined: SHALL apply truncation and DRAIN per REQ-017/021/022.
REQ-030 AXIS_WR_DESC_DRAIN_EN undefined: SHALL omit DRAIN and masking; XFER ends only on s_axis_tlast; counter counts all bytes; error=1 if counter!=len.

Verification (DATA_WIDTH=512)
REQ-031 Desc len=128, tag=0x5, 2 full beats, last on beat 2 -> one base_addr pulse, 2 beats out, status len=128, error=0.
REQ-032 Desc len=100, 2 full beats, tlast on beat 2 -> beat 2 tkeep=0x0000000FFFFFFFFF with tlast, status len=100, error=0.
REQ-033 Desc len=64, 3 beats, tlast on beat 3 (drain on) -> 1 beat out with tlast, 2 beats dropped, status len=64, error=1.
REQ-034 Desc len=200, 1 beat tkeep all-ones with tlast -> status len=64, error=1; desc len=0 -> status within 2 cycles, error=1, no base_addr pulse.
REQ-035 m_axis_tready toggled 50% during the REQ-031 case -> no beat lost or duplicated; rst asserted mid-XFER -> no status, IDLE next cycle.
